// File: rtl/peak_event_pkg.sv
// Shared types for the peak event detector: FSM state, event record layout,
// drop counter width and its saturating increment.
package peak_event_pkg;

  localparam int DATA_W  = 16;
  localparam int TS_W    = 32;
  localparam int WIDTH_W = 10;
  localparam int DROP_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    EMIT  = 2'd2,
    DEAD  = 2'd3
  } state_e;

  typedef struct packed {
    logic signed [DATA_W-1:0] amplitude;
    logic [TS_W-1:0]          timestamp;
    logic [WIDTH_W-1:0]       width;
    logic                     truncated;
    logic                     pileup;
  } event_rec_t;

  function automatic logic [DROP_W-1:0] sat_inc_drop(input logic [DROP_W-1:0] v);
    if (v == {DROP_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(DROP_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/peak_event_outreg.sv
// Single-entry valid/ready holding register. A load is accepted when the slot is
// empty or is being drained in the same cycle; otherwise the load is dropped.
module peak_event_outreg
  import peak_event_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  event_rec_t load_rec,
  input  logic       out_ready,
  output logic       out_valid,
  output event_rec_t out_rec,
  output logic       drop
);

  logic       valid_q, valid_d;
  event_rec_t rec_q, rec_d;
  logic       free_s;

  // Load/accept/drop decision for the holding slot
  always_comb begin
    free_s  = !valid_q || out_ready;
    valid_d = valid_q;
    rec_d   = rec_q;
    drop    = 1'b0;
    if (load) begin
      if (free_s) begin
        valid_d = 1'b1;
        rec_d   = load_rec;
      end else begin
        drop = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Slot registers
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      rec_q   <= {$bits(event_rec_t){1'b0}};
    end else begin
      valid_q <= valid_d;
      rec_q   <= rec_d;
    end
  end

  assign out_valid = valid_q;
  assign out_rec   = rec_q;

endmodule

// File: rtl/peak_event_detector.sv
// Threshold-triggered pulse detector: one peak/timestamp/width record per pulse.
// Optional pile-up flagging is built only when PEAK_PILEUP_DETECT_EN is defined.
module peak_event_detector
  import peak_event_pkg::*;
#(
  parameter int SIZE_FILTER_DATA = DATA_W,
  parameter int TS_WIDTH         = TS_W,
  parameter int WIDTH_BITS       = WIDTH_W,
  parameter int MAX_WIDTH        = 1023,
  parameter int DEAD_TIME        = 8,
  parameter int PILEUP_HYST      = 64
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic signed [SIZE_FILTER_DATA-1:0] filter_data,
  input  logic signed [SIZE_FILTER_DATA-1:0] threshold,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic signed [SIZE_FILTER_DATA-1:0] out_amplitude,
  output logic [TS_WIDTH-1:0]                out_timestamp,
  output logic [WIDTH_BITS-1:0]              out_width,
  output logic                               out_truncated,
  output logic                               out_pileup,
  output logic [DROP_W-1:0]                  drop_count,
  output logic                               busy
);

  localparam int DEAD_CW = (DEAD_TIME > 3) ? $clog2(DEAD_TIME + 1) : 2;

  state_e                             state_q, state_d;
  logic [TS_WIDTH-1:0]                ts_q, ts_d, peak_ts_q, peak_ts_d;
  logic signed [SIZE_FILTER_DATA-1:0] peak_q, peak_d;
  logic [WIDTH_BITS-1:0]              width_q, width_d, width_inc;
  logic                               trunc_q, trunc_d;
  logic [DEAD_CW-1:0]                 dead_q, dead_d;
  logic [DROP_W-1:0]                  drop_count_q, drop_count_d;
  logic                               busy_q;
  logic                               above, pileup_s, emit_load, drop_s;
  event_rec_t                         emit_rec, held_rec;

  assign above     = filter_data > threshold;
  assign width_inc = width_q + WIDTH_BITS'(1);

  // Pulse tracker next-state and datapath
  always_comb begin
    state_d   = state_q;
    ts_d      = ts_q + TS_WIDTH'(1);
    peak_d    = peak_q;
    peak_ts_d = peak_ts_q;
    width_d   = width_q;
    trunc_d   = trunc_q;
    dead_d    = dead_q;
    case (state_q)
      IDLE: begin
        if (above) begin
          state_d   = TRACK;
          peak_d    = filter_data;
          peak_ts_d = ts_q;
          width_d   = WIDTH_BITS'(1);
          trunc_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      TRACK: begin
        if (!above) begin
          state_d = EMIT;
        end else begin
          width_d = width_inc;
          // strict compare keeps the earliest sample of a plateau
          if (filter_data > peak_q) begin
            peak_d    = filter_data;
            peak_ts_d = ts_q;
          end else begin
            peak_d    = peak_q;
          end
          if (width_inc == WIDTH_BITS'(MAX_WIDTH)) begin
            state_d = EMIT;
            trunc_d = 1'b1;
          end else begin
            state_d = TRACK;
          end
        end
      end
      EMIT: begin
        if (DEAD_TIME == 0) begin
          state_d = IDLE;
        end else begin
          state_d = DEAD;
          dead_d  = DEAD_CW'(DEAD_TIME);
        end
      end
      DEAD: begin
        dead_d = dead_q - DEAD_CW'(1);
        if (dead_q <= DEAD_CW'(2)) begin
          state_d = IDLE;
        end else begin
          state_d = DEAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Saturating count of records lost to an occupied output register
  always_comb begin
    if (drop_s) begin
      drop_count_d = sat_inc_drop(drop_count_q);
    end else begin
      drop_count_d = drop_count_q;
    end
  end

  // FSM, timestamp and pulse registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ts_q         <= {TS_WIDTH{1'b0}};
      peak_q       <= {SIZE_FILTER_DATA{1'b0}};
      peak_ts_q    <= {TS_WIDTH{1'b0}};
      width_q      <= {WIDTH_BITS{1'b0}};
      trunc_q      <= 1'b0;
      dead_q       <= {DEAD_CW{1'b0}};
      drop_count_q <= {DROP_W{1'b0}};
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ts_q         <= ts_d;
      peak_q       <= peak_d;
      peak_ts_q    <= peak_ts_d;
      width_q      <= width_d;
      trunc_q      <= trunc_d;
      dead_q       <= dead_d;
      drop_count_q <= drop_count_d;
      busy_q       <= (state_d != IDLE);
    end
  end

`ifdef PEAK_PILEUP_DETECT_EN
  localparam int EXT_W = SIZE_FILTER_DATA + 2;

  logic signed [EXT_W-1:0]            hyst_ext, data_ext, peak_ext, min_ext;
  logic signed [SIZE_FILTER_DATA-1:0] min_q, min_d;
  logic                               falling_q, falling_d, pile_q, pile_d;

  assign hyst_ext = EXT_W'(PILEUP_HYST);
  assign data_ext = EXT_W'(filter_data);
  assign peak_ext = EXT_W'(peak_q);
  assign min_ext  = EXT_W'(min_q);

  // Fall below peak by the hysteresis, then re-rise above the running minimum
  always_comb begin
    falling_d = falling_q;
    pile_d    = pile_q;
    min_d     = min_q;
    if (state_q == IDLE && above) begin
      falling_d = 1'b0;
      pile_d    = 1'b0;
      min_d     = {SIZE_FILTER_DATA{1'b0}};
    end else if (state_q == TRACK && above) begin
      if (falling_q) begin
        if (data_ext >= min_ext + hyst_ext) begin
          pile_d = 1'b1;
        end else begin
          pile_d = pile_q;
        end
        if (filter_data < min_q) begin
          min_d = filter_data;
        end else begin
          min_d = min_q;
        end
      end else if (data_ext <= peak_ext - hyst_ext) begin
        falling_d = 1'b1;
        min_d     = filter_data;
      end else begin
        falling_d = falling_q;
      end
    end else begin
      falling_d = falling_q;
    end
  end

  // Pile-up tracking registers
  always_ff @(posedge clk) begin
    if (reset) begin
      falling_q <= 1'b0;
      pile_q    <= 1'b0;
      min_q     <= {SIZE_FILTER_DATA{1'b0}};
    end else begin
      falling_q <= falling_d;
      pile_q    <= pile_d;
      min_q     <= min_d;
    end
  end

  assign pileup_s = pile_q;
`else
  assign pileup_s = 1'b0;
`endif

  assign emit_load          = (state_q == EMIT);
  assign emit_rec.amplitude = peak_q;
  assign emit_rec.timestamp = peak_ts_q;
  assign emit_rec.width     = width_q;
  assign emit_rec.truncated = trunc_q;
  assign emit_rec.pileup    = pileup_s;

  peak_event_outreg u_outreg (
    .clk       (clk),
    .reset     (reset),
    .load      (emit_load),
    .load_rec  (emit_rec),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_rec   (held_rec),
    .drop      (drop_s)
  );

  assign out_amplitude = held_rec.amplitude;
  assign out_timestamp = held_rec.timestamp;
  assign out_width     = held_rec.width;
  assign out_truncated = held_rec.truncated;
  assign out_pileup    = held_rec.pileup;
  assign drop_count    = drop_count_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_peak_event_detector.sv
// Self-checking bench for peak_event_detector: directed scenarios plus randomized
// pulse trains checked against a pulse-level reference model.
module tb_peak_event_detector;

  localparam int DW = 16, TSW = 32, WB = 10, MAXW = 1023, DEADT = 8, HYST = 64;
  localparam int NMAX = 1200, NEV = 256;
`ifdef PEAK_PILEUP_DETECT_EN
  localparam bit PILE_ON = 1'b1;
`else
  localparam bit PILE_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic signed [DW-1:0] filter_data, threshold;
  logic out_valid, out_ready, out_truncated, out_pileup, busy;
  logic signed [DW-1:0] out_amplitude;
  logic [TSW-1:0] out_timestamp;
  logic [WB-1:0] out_width;
  logic [15:0] drop_count;

  int n_vec = 0;
  int n_err = 0;

  int s[NMAX];
  bit rdy[NMAX];
  int thr_i;
  int emit_ev[NMAX];
  int ev_amp[NEV], ev_ts[NEV], ev_w[NEV];
  bit ev_tr[NEV], ev_pu[NEV];
  bit e_valid[NMAX], e_busy[NMAX], e_tr[NMAX], e_pu[NMAX];
  int e_amp[NMAX], e_ts[NMAX], e_w[NMAX], e_drop[NMAX];

  always #5 clk = ~clk;

  peak_event_detector dut (
    .clk(clk), .reset(reset), .filter_data(filter_data), .threshold(threshold),
    .out_valid(out_valid), .out_ready(out_ready), .out_amplitude(out_amplitude),
    .out_timestamp(out_timestamp), .out_width(out_width), .out_truncated(out_truncated),
    .out_pileup(out_pileup), .drop_count(drop_count), .busy(busy)
  );

  // Inputs change on the falling edge; outputs seen then belong to the coming cycle.
  task automatic step(input int d, input bit r);
    @(negedge clk);
    reset       = 1'b0;
    filter_data = DW'(d);
    out_ready   = r;
  endtask

  task automatic do_reset(input int idle);
    @(negedge clk);
    reset       = 1'b1;
    filter_data = DW'(idle);
    out_ready   = 1'b0;
    @(posedge clk);
  endtask

  function automatic int quiet();
    return int'($urandom_range(100));
  endfunction

  // Pulse-level reference: find pulses in s[], then replay the output handshake.
  task automatic build_model(input int n);
    int i, j, k, e, peak, pts, mn, nev, drop;
    bit trunc, falling, pile, hv;
    int h_amp, h_ts, h_w;
    bit h_tr, h_pu;
    nev = 0;
    for (int c = 0; c < n; c++) begin
      e_busy[c] = 1'b0;
      emit_ev[c] = -1;
    end
    i = 0;
    while (i < n) begin
      if (s[i] <= thr_i) begin
        i++;
      end else begin
        k = 1; peak = s[i]; pts = i; trunc = 0; falling = 0; pile = 0; mn = 0; e = -1;
        j = i + 1;
        while (j < n && e < 0) begin
          if (s[j] <= thr_i) begin
            e = j;
          end else begin
            k++;
            if (falling) begin
              if (s[j] >= mn + HYST) pile = 1;
              if (s[j] < mn) mn = s[j];
            end else if (s[j] <= peak - HYST) begin
              falling = 1;
              mn = s[j];
            end
            if (s[j] > peak) begin
              peak = s[j];
              pts = j;
            end
            if (k == MAXW) begin
              trunc = 1;
              e = j;
            end
            j++;
          end
        end
        if (e < 0) begin
          for (int c = i + 1; c < n; c++) e_busy[c] = 1'b1;
          i = n;
        end else begin
          for (int c = i + 1; c <= e + DEADT && c < n; c++) e_busy[c] = 1'b1;
          if (e + 1 < n && nev < NEV) begin
            ev_amp[nev] = peak; ev_ts[nev] = pts; ev_w[nev] = k;
            ev_tr[nev] = trunc; ev_pu[nev] = pile & PILE_ON;
            emit_ev[e + 1] = nev;
            nev++;
          end
          i = e + 1 + DEADT;
        end
      end
    end
    hv = 0; drop = 0; h_amp = 0; h_ts = 0; h_w = 0; h_tr = 0; h_pu = 0;
    for (int c = 0; c < n; c++) begin
      e_valid[c] = hv; e_amp[c] = h_amp; e_ts[c] = h_ts; e_w[c] = h_w;
      e_tr[c] = h_tr; e_pu[c] = h_pu; e_drop[c] = drop;
      if (emit_ev[c] >= 0) begin
        if (!hv || rdy[c]) begin
          hv = 1;
          h_amp = ev_amp[emit_ev[c]]; h_ts = ev_ts[emit_ev[c]]; h_w = ev_w[emit_ev[c]];
          h_tr = ev_tr[emit_ev[c]]; h_pu = ev_pu[emit_ev[c]];
        end else if (drop < 65535) begin
          drop++;
        end
      end else if (hv && rdy[c]) begin
        hv = 0;
      end
    end
  endtask

  task automatic test_reset();
    threshold = 16'sd100;
    do_reset(0);
    step(0, 1'b1);
    n_vec++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || drop_count !== 16'd0) begin
      n_err++;
      $display("FAIL reset_ctrl: valid=%b busy=%b drop=%0d want 0 0 0", out_valid, busy, drop_count);
    end
    n_vec++;
    if (out_amplitude !== 16'sd0 || out_timestamp !== 32'd0 || out_width !== 10'd0 ||
        out_truncated !== 1'b0 || out_pileup !== 1'b0) begin
      n_err++;
      $display("FAIL reset_payload: amp=%0d ts=%0d w=%0d tr=%b pu=%b want all 0",
               out_amplitude, out_timestamp, out_width, out_truncated, out_pileup);
    end
  endtask

  task automatic test_basic();
    int pat[8] = '{0, 50, 150, 300, 500, 400, 200, 90};
    threshold = 16'sd100;
    do_reset(0);
    for (int c = 0; c < 24; c++) begin
      step((c >= 10 && c <= 17) ? pat[c - 10] : quiet(), 1'b1);
      if (c == 13) begin
        n_vec++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b want 1", busy); end
      end
      if (c == 18 || c == 20) begin
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_c%0d: got %b want 0", c, out_valid); end
      end
      if (c == 19) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_amplitude !== 16'sd500 || out_timestamp !== 32'd14 ||
            out_width !== 10'd5 || out_truncated !== 1'b0) begin
          n_err++;
          $display("FAIL basic_rec: v=%b amp=%0d ts=%0d w=%0d tr=%b want 1 500 14 5 0",
                   out_valid, out_amplitude, out_timestamp, out_width, out_truncated);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int d;
    threshold = 16'sd100;
    do_reset(0);
    for (int c = 0; c < 40; c++) begin
      case (c)
        5, 7, 25, 27: d = 200;
        6:            d = 500;
        26:           d = 700;
        default:      d = quiet();
      endcase
      step(d, c >= 35);
      if (c == 10) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_amplitude !== 16'sd500 || out_timestamp !== 32'd6 || out_width !== 10'd3) begin
          n_err++;
          $display("FAIL bp_first: v=%b amp=%0d ts=%0d w=%0d want 1 500 6 3", out_valid, out_amplitude, out_timestamp, out_width);
        end
      end
      if (c == 30 || c == 35) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_amplitude !== 16'sd500 || out_timestamp !== 32'd6 || drop_count !== 16'd1) begin
          n_err++;
          $display("FAIL bp_held_c%0d: v=%b amp=%0d ts=%0d drop=%0d want 1 500 6 1", c, out_valid, out_amplitude, out_timestamp, drop_count);
        end
      end
      if (c == 36) begin
        n_vec++;
        if (out_valid !== 1'b0 || drop_count !== 16'd1) begin
          n_err++;
          $display("FAIL bp_drain: v=%b drop=%0d want 0 1", out_valid, drop_count);
        end
      end
    end
  endtask

  task automatic test_truncation();
    threshold = 16'sd100;
    do_reset(0);
    for (int c = 0; c < 1106; c++) begin
      step((c < 1100) ? 200 : 0, 1'b1);
      if (c == 1023) begin
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL trunc_emit_cycle: v=%b want 0", out_valid); end
      end
      if (c == 1024) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_width !== 10'd1023 || out_truncated !== 1'b1 ||
            out_amplitude !== 16'sd200 || out_timestamp !== 32'd0) begin
          n_err++;
          $display("FAIL trunc_first: v=%b w=%0d tr=%b amp=%0d ts=%0d want 1 1023 1 200 0",
                   out_valid, out_width, out_truncated, out_amplitude, out_timestamp);
        end
      end
      if (c == 1030 || c == 1031) begin
        n_vec++;
        if (busy !== (c == 1030)) begin
          n_err++;
          $display("FAIL trunc_dead_c%0d: busy=%b want %b", c, busy, c == 1030);
        end
      end
      if (c == 1102) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_width !== 10'd69 || out_truncated !== 1'b0 || out_timestamp !== 32'd1031) begin
          n_err++;
          $display("FAIL trunc_second: v=%b w=%0d tr=%b ts=%0d want 1 69 0 1031",
                   out_valid, out_width, out_truncated, out_timestamp);
        end
      end
    end
  endtask

  task automatic test_ties_signed();
    int nev_seen, d;
    threshold = 16'sd100;
    do_reset(0);
    for (int c = 0; c < 48; c++) begin
      step((c >= 40 && c <= 42) ? 300 : quiet(), 1'b1);
      if (c == 45) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_timestamp !== 32'd40 || out_width !== 10'd3 || out_amplitude !== 16'sd300) begin
          n_err++;
          $display("FAIL tie_rec: v=%b ts=%0d w=%0d amp=%0d want 1 40 3 300", out_valid, out_timestamp, out_width, out_amplitude);
        end
      end
    end
    threshold = -16'sd50;
    do_reset(-200);
    nev_seen = 0;
    for (int c = 0; c < 30; c++) begin
      case (c)
        10:      d = -100;
        11:      d = -20;
        12:      d = -60;
        default: d = -50 - int'($urandom_range(250));
      endcase
      step(d, 1'b1);
      if (out_valid === 1'b1) nev_seen++;
      if (c == 14) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_amplitude !== -16'sd20 || out_width !== 10'd1 || out_timestamp !== 32'd11) begin
          n_err++;
          $display("FAIL signed_rec: v=%b amp=%0d w=%0d ts=%0d want 1 -20 1 11", out_valid, out_amplitude, out_width, out_timestamp);
        end
      end
    end
    n_vec++;
    if (nev_seen != 1) begin n_err++; $display("FAIL signed_count: got %0d events want 1", nev_seen); end
  endtask

  task automatic test_reset_mid_track();
    int bad;
    threshold = 16'sd100;
    do_reset(0);
    for (int c = 0; c < 100; c++) begin
      step((c < 5) ? quiet() : 500, 1'b1);
    end
    n_vec++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_pre: busy=%b v=%b want 1 0", busy, out_valid);
    end
    do_reset(500);
    bad = 0;
    for (int c = 0; c < 14; c++) begin
      step((c == 7) ? 300 : quiet(), 1'b1);
      if (c == 0) begin
        n_vec++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || drop_count !== 16'd0) begin
          n_err++;
          $display("FAIL midrst_post: v=%b busy=%b drop=%0d want 0 0 0", out_valid, busy, drop_count);
        end
      end
      if (c >= 1 && c <= 7 && (busy !== 1'b0 || out_valid !== 1'b0)) bad++;
      if (c == 10) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_timestamp !== 32'd7 || out_amplitude !== 16'sd300 || out_width !== 10'd1) begin
          n_err++;
          $display("FAIL midrst_ts: v=%b ts=%0d amp=%0d w=%0d want 1 7 300 1", out_valid, out_timestamp, out_amplitude, out_width);
        end
      end
    end
    n_vec++;
    if (bad != 0) begin n_err++; $display("FAIL midrst_quiet: %0d busy/valid cycles want 0", bad); end
  endtask

  task automatic test_pileup();
    int pat[6] = '{0, 500, 300, 250, 400, 0};
    threshold = 16'sd100;
    do_reset(0);
    for (int c = 0; c < 14; c++) begin
      step((c >= 4 && c <= 9) ? pat[c - 4] : quiet(), 1'b1);
      if (c == 11) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_amplitude !== 16'sd500 || out_timestamp !== 32'd5 ||
            out_width !== 10'd4 || out_pileup !== PILE_ON || out_truncated !== 1'b0) begin
          n_err++;
          $display("FAIL pileup_rec: v=%b amp=%0d ts=%0d w=%0d pu=%b tr=%b want 1 500 5 4 %b 0",
                   out_valid, out_amplitude, out_timestamp, out_width, out_pileup, out_truncated, PILE_ON);
        end
      end
    end
  endtask

  task automatic test_random();
    int n, c, len, rp;
    int rprob[4] = '{80, 50, 15, 100};
    n = 500;
    for (int r = 0; r < 6; r++) begin
      thr_i = int'($urandom_range(600)) - 300;
      rp = rprob[r % 4];
      c = 0;
      while (c < n) begin
        if ($urandom_range(99) < 8) begin
          len = int'($urandom_range(60, 1));
          for (int k = 0; k < len && c < n; k++) begin
            s[c] = thr_i - 80 + int'($urandom_range(1000));
            c++;
          end
        end else begin
          s[c] = thr_i - int'($urandom_range(200));
          c++;
        end
      end
      for (int k = 0; k < n; k++) rdy[k] = ($urandom_range(99) < rp);
      build_model(n);
      threshold = DW'(thr_i);
      do_reset(0);
      for (int k = 0; k < n; k++) begin
        step(s[k], rdy[k]);
        n_vec++;
        if (out_valid !== e_valid[k] || busy !== e_busy[k] || drop_count !== 16'(e_drop[k])) begin
          n_err++;
          $display("FAIL rand_ctrl r%0d c%0d: v=%b busy=%b drop=%0d want %b %b %0d",
                   r, k, out_valid, busy, drop_count, e_valid[k], e_busy[k], e_drop[k]);
        end
        if (e_valid[k]) begin
          n_vec++;
          if (out_amplitude !== 16'(e_amp[k]) || out_timestamp !== 32'(e_ts[k]) || out_width !== 10'(e_w[k]) ||
              out_truncated !== e_tr[k] || out_pileup !== e_pu[k]) begin
            n_err++;
            $display("FAIL rand_rec r%0d c%0d: amp=%0d ts=%0d w=%0d tr=%b pu=%b want %0d %0d %0d %b %b",
                     r, k, out_amplitude, out_timestamp, out_width, out_truncated, out_pileup,
                     e_amp[k], e_ts[k], e_w[k], e_tr[k], e_pu[k]);
          end
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset       = 1'b1;
    filter_data = 16'sd0;
    threshold   = 16'sd0;
    out_ready   = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_truncation();
    test_ties_signed();
    test_reset_mid_track();
    test_pileup();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/peak_event_detector.md
Name: peak_event_detector

Overview:
- Downstream consumer of the shaping-filter output; one signed filter sample per clock, no valid strobe.
- Detects pulses crossing a programmable threshold and captures each pulse's peak amplitude, peak timestamp and width.
- Emits one event record per pulse over a valid/ready interface to the readout/histogram stage.
- Counts events lost to backpressure.

Parameters:
- SIZE_FILTER_DATA, 16: filter sample width, signed two's complement.
- TS_WIDTH, 32: free-running timestamp counter width.
- WIDTH_BITS, 10: pulse-width counter width.
- MAX_WIDTH, 1023: forced pulse end after this many above-threshold samples; must be ≤ 2^WIDTH_BITS-1.
- DEAD_TIME, 8: cycles of retrigger holdoff after each pulse end.
- PILEUP_HYST, 64: hysteresis for pile-up detection; used only with the optional feature.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- filter_data  in  SIZE_FILTER_DATA  signed filter sample, new value every clock.
- threshold  in  SIZE_FILTER_DATA  signed trigger level; quasi-static, live value used every cycle.
- out_valid  out  1  event record available.
- out_ready  in  1  consumer accepts the record.
- out_amplitude  out  SIZE_FILTER_DATA  signed peak value.
- out_timestamp  out  TS_WIDTH  timestamp of the peak sample.
- out_width  out  WIDTH_BITS  number of above-threshold samples.
- out_truncated  out  1  pulse was ended by MAX_WIDTH.
- out_pileup  out  1  pile-up seen during the pulse.
- drop_count  out  16  events lost to backpressure, saturating.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, on port reset.
- Reset values: all outputs 0; timestamp counter 0; FSM in IDLE; all internal registers 0. Reset mid-pulse discards the pulse and any held record.
- Timestamp counter: increments every cycle and wraps modulo 2^TS_WIDTH. "ts of a sample" is the counter value in the cycle that sample is on filter_data.
- Comparisons: all signed.
- FSM states: IDLE, TRACK, EMIT, DEAD.
- IDLE:
  - If filter_data > threshold: go to TRACK; peak <= sample; peak_ts <= ts; width <= 1.
  - Equal to threshold does not trigger.
- TRACK:
  - If filter_data <= threshold: go to EMIT. This sample is not counted in width.
  - Else: width++. If filter_data > peak strictly, update peak and peak_ts, so ties keep the earliest timestamp.
  - If width reaches MAX_WIDTH: go to EMIT with truncated=1, regardless of the current sample.
- EMIT (exactly one cycle):
  - Output register is free if out_valid=0, or if out_valid=1 and out_ready=1 in this same cycle. If free, load the record and out_valid <= 1.
  - If not free, drop the record; drop_count++, saturating at 0xFFFF.
  - Next state: DEAD with counter=DEAD_TIME; go directly to IDLE if DEAD_TIME=0.
- DEAD:
  - Counter decrements each cycle; go to IDLE when it reaches 1.
  - Input is ignored, so a pulse still above threshold retriggers on the first IDLE cycle.
- Latency: out_valid rises at the second rising edge after the terminating sample is presented.
- Output handshake:
  - Record transfers on any cycle with out_valid && out_ready.
  - Payload is held stable while out_valid=1 && out_ready=0.
  - out_valid drops after a transfer unless EMIT reloads in the same cycle.
- busy = (state != IDLE).

Optional Feature:
- Macro: PEAK_PILEUP_DETECT_EN.
- Defined:
  - In TRACK, once a sample is ≤ peak - PILEUP_HYST, a falling flag sets and a running minimum is tracked.
  - While falling, a sample ≥ min + PILEUP_HYST sets the pile-up flag.
  - Peak tracking continues unchanged. All pile-up state clears on entry to TRACK.
- Undefined: no pile-up logic is synthesized; out_pileup is tied 0. The port exists in both builds.

Decomposition:
- Package peak_event_pkg holds:
  - the FSM state enum;
  - the event record struct (amplitude, timestamp, width, truncated, pileup);
  - drop-counter width constant 16.
- One sub-module: peak_event_outreg, a single-entry valid/ready holding register with a load/accept-same-cycle rule and a drop strobe.

Test Plan:
- Basic pulse: threshold=100; samples 0,50,150,300,500,400,200,90 at ts 10..17; out_ready=1 -> out_amplitude=500, out_timestamp=14, out_width=5, truncated=0; out_valid high 2 edges after ts17; one-cycle valid.
- Backpressure: out_ready=0; two pulses with peaks 500 and 700, gap > DEAD_TIME -> record 500 held unchanged, drop_count=1. Raising out_ready -> one transfer, then out_valid=0.
- Truncation: threshold=100; constant 200 for 1100 cycles -> first record width=1023, truncated=1. Second record starts on the first IDLE cycle after 8 DEAD cycles, with width=1100-1023-8=69, truncated=0.
- Ties and signed values: plateau 300,300,300 at ts 40..42 -> timestamp 40. Threshold=-50 with samples -100,-20,-60 -> one event, amplitude -20, width 1.
- Reset mid-TRACK: assert reset during a 500-sample pulse -> next cycle out_valid=0, busy=0, drop_count=0, ts=0. No event from the remainder if the post-reset input stays at or below threshold.
- Pile-up, macro defined: 0,500,300,250,400,0 with threshold=100 -> amplitude 500, pileup=1. Same stimulus with macro undefined -> pileup=0.
